// File: rtl/note_scroller_if.sv
// note_scroller_if
// Spawn handshake between the chart reader (master) and the note scroller
// (slave). A note transfers on any clock edge where valid and ready are
// both high.
//   spawn_valid  master->slave  a chart note is offered
//   spawn_color  master->slave  note color, 0 = red, 1 = blue
//   spawn_ready  slave->master  the scroller's holding register is free
interface note_scroller_if;
  logic spawn_valid;
  logic spawn_color;
  logic spawn_ready;

  modport master (output spawn_valid, output spawn_color, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_color, output spawn_ready);
endinterface

// File: rtl/note_scroller.sv
// note_scroller
// Drum-game note track. Notes enter through a one-deep holding register.
// They then scroll from slot 9 toward the hit zone at slot 0, moving one
// pixel (offset step) per tick. A slot shift happens every 7 ticks. Pad
// strikes are judged against slot 0, and score and combo are kept for the
// score display.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   spawn             spawn handshake (slave side of note_scroller_if)
//   tick              one-cycle scroll-step strobe
//   hit_red/hit_blue  one-cycle pad strikes
//   red_notes/blue_notes  per-slot occupancy (bit i = slot i)
//   offset            pixel shift within a slot, 0..6
//   ev_good/ok/bad/miss   one-cycle judgment pulses
//   score             saturating point total
//   combo             saturating count of consecutive successful hits
module note_scroller #(
  parameter int SCORE_W  = 16,
  parameter int GOOD_PTS = 2,
  parameter int OK_PTS   = 1,
  parameter int GOOD_WIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  note_scroller_if.slave     spawn,
  input  logic               tick,
  input  logic               hit_red,
  input  logic               hit_blue,
  output logic [9:0]         red_notes,
  output logic [9:0]         blue_notes,
  output logic [2:0]         offset,
  output logic               ev_good,
  output logic               ev_ok,
  output logic               ev_bad,
  output logic               ev_miss,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo
);

  localparam logic [2:0]       LAST_OFFSET = 3'd6;
  localparam logic [2:0]       GOOD_WIN_L  = 3'(GOOD_WIN);
  localparam logic [SCORE_W:0] GOOD_INC    = (SCORE_W+1)'(GOOD_PTS);
  localparam logic [SCORE_W:0] OK_INC      = (SCORE_W+1)'(OK_PTS);

  logic [9:0]         red_q, red_d, blue_q, blue_d;
  logic               hold_valid_q, hold_valid_d;
  logic               hold_color_q, hold_color_d;
  logic [2:0]         offset_q, offset_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic               ev_good_q, ev_good_d, ev_ok_q, ev_ok_d;
  logic               ev_bad_q, ev_bad_d, ev_miss_q, ev_miss_d;

  logic               xfer;
  logic               hit_blue_sel;
  logic               slot0_match;
  logic [SCORE_W:0]   score_sum;

  assign spawn.spawn_ready = ~hold_valid_q & ~rst;
  assign xfer              = spawn.spawn_valid & spawn.spawn_ready;

  // Exactly one pad is active when this matters, so hit_blue alone selects
  // the lane.
  assign hit_blue_sel = hit_blue;
  assign slot0_match  = hit_blue_sel ? blue_q[0] : red_q[0];

  // NOTE: every signal written below gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    red_d        = red_q;
    blue_d       = blue_q;
    hold_valid_d = hold_valid_q;
    hold_color_d = hold_color_q;
    offset_d     = offset_q;
    score_d      = score_q;
    combo_d      = combo_q;
    ev_good_d    = 1'b0;
    ev_ok_d      = 1'b0;
    ev_bad_d     = 1'b0;
    ev_miss_d    = 1'b0;
    score_sum    = '0;

    // The hit is judged on pre-update state, before any shift this cycle.
    // The shift below then works on the post-hit lanes, so a successful
    // hit on the shift edge never also counts as a miss.
    if (hit_red ^ hit_blue) begin
      if (slot0_match) begin
        if (hit_blue_sel) blue_d[0] = 1'b0;
        else              red_d[0]  = 1'b0;
        if (offset_q <= GOOD_WIN_L) begin
          ev_good_d = 1'b1;
          score_sum = {1'b0, score_q} + GOOD_INC;
        end else begin
          ev_ok_d   = 1'b1;
          score_sum = {1'b0, score_q} + OK_INC;
        end
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (combo_q != 8'hFF) combo_d = combo_q + 8'd1;
      end else begin
        ev_bad_d = 1'b1;
        combo_d  = '0;
      end
    end

    if (tick) begin
      if (offset_q == LAST_OFFSET) begin
        offset_d = '0;
        if (red_d[0] | blue_d[0]) begin
          ev_miss_d = 1'b1;
          combo_d   = '0;
        end
        // Slot 9 is fed from the holding register as it was before this
        // cycle; a note accepted this cycle waits for the next shift.
        red_d        = {hold_valid_q & ~hold_color_q, red_d[9:1]};
        blue_d       = {hold_valid_q &  hold_color_q, blue_d[9:1]};
        hold_valid_d = 1'b0;
      end else begin
        offset_d = offset_q + 3'd1;
      end
    end

    if (xfer) begin
      hold_valid_d = 1'b1;
      hold_color_d = spawn.spawn_color;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      red_q        <= '0;
      blue_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_color_q <= 1'b0;
      offset_q     <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      ev_good_q    <= 1'b0;
      ev_ok_q      <= 1'b0;
      ev_bad_q     <= 1'b0;
      ev_miss_q    <= 1'b0;
    end else begin
      red_q        <= red_d;
      blue_q       <= blue_d;
      hold_valid_q <= hold_valid_d;
      hold_color_q <= hold_color_d;
      offset_q     <= offset_d;
      score_q      <= score_d;
      combo_q      <= combo_d;
      ev_good_q    <= ev_good_d;
      ev_ok_q      <= ev_ok_d;
      ev_bad_q     <= ev_bad_d;
      ev_miss_q    <= ev_miss_d;
    end
  end

  assign red_notes  = red_q;
  assign blue_notes = blue_q;
  assign offset     = offset_q;
  assign score      = score_q;
  assign combo      = combo_q;
  assign ev_good    = ev_good_q;
  assign ev_ok      = ev_ok_q;
  assign ev_bad     = ev_bad_q;
  assign ev_miss    = ev_miss_q;

endmodule
